hankel_sample_buf: RTL and testbench

Ping-pong sample buffer sitting directly upstream of hankel_matrixd_d.
- Captures a streaming input of 16-bit samples into one of two frame banks.
- Announces each completed frame to the Hankel builder with a one-cycle start pulse.
- Serves the builder's random-access reads (rd/addr -> data), while the other bank keeps filling.

---
 rtl/hankel_pkg.sv | 29 ++
 rtl/hankel_sample_buf_if.sv | 35 +++
 rtl/sample_bank_ram.sv | 46 ++++
 rtl/hankel_sample_buf.sv | 154 +++++++++++++++
 tb/tb_hankel_sample_buf.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/hankel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hankel_pkg
// Description : Shared widths, bank-state encoding and fill pattern for the
//               Hankel front-end sample buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package hankel_pkg;

    localparam int HK_DW        = 16;
    localparam int HK_AW        = 8;
    localparam int HK_FRAME_LEN = 64;

    localparam logic [15:0] FILL_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_e;

    // A bank holding a complete frame cannot accept samples.
    function automatic logic is_held(input bank_state_e s);
        return (s == BANK_FULL) || (s == BANK_READING);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hankel_sample_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : hankel_sample_buf_if
// Description : Sample stream, builder read port and status bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface hankel_sample_buf_if
    import hankel_pkg::*;
#(
    parameter int DW = HK_DW,
    parameter int AW = HK_AW
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          start;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          frame_done;
    logic [1:0]    frames_pending;
    logic          err;

    modport master (
        output in_data, in_valid, rd, addr, frame_done,
        input  in_ready, start, data, frames_pending, err
    );

    modport slave (
        input  in_data, in_valid, rd, addr, frame_done,
        output in_ready, start, data, frames_pending, err
    );

endinterface
`default_nettype wire

// File: rtl/sample_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : sample_bank_ram
// Description : Simple dual-port RAM, one write port and one registered read
//               port holding both frame banks.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_bank_ram
    import hankel_pkg::*;
#(
    parameter int DW    = HK_DW,
    parameter int DEPTH = 2 * HK_FRAME_LEN,
    parameter int ABITS = $clog2(2 * HK_FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [ABITS-1:0] waddr_i,
    input  logic [DW-1:0]    wdata_i,
    input  logic             re_i,
    input  logic [ABITS-1:0] raddr_i,
    output logic [DW-1:0]    rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Output register only moves on a read, so it holds between requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/hankel_sample_buf.sv
`default_nettype none
// ============================================================================
// Module      : hankel_sample_buf
// Description : Ping-pong frame buffer feeding the Hankel builder: fills one
//               bank from the stream while the builder reads the other.
// Revision    : 1.0 - initial release
// ============================================================================
module hankel_sample_buf
    import hankel_pkg::*;
#(
    parameter int DW        = HK_DW,
    parameter int AW        = HK_AW,
    parameter int FRAME_LEN = HK_FRAME_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    hankel_sample_buf_if.slave  bus
);

    localparam int IW  = $clog2(FRAME_LEN);
    localparam int RAW = IW + 1;
    localparam int AW1 = AW + 1;

    localparam logic [IW-1:0]  c_last_idx   = IW'(FRAME_LEN - 1);
    localparam logic [AW1-1:0] c_frame_len  = AW1'(FRAME_LEN);
    localparam logic [RAW-1:0] c_bank1_base = RAW'(FRAME_LEN);

    bank_state_e   bank_q [2];
    bank_state_e   bank_d [2];
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [IW-1:0] wr_cnt_q, wr_cnt_d;
    logic          start_q, start_d;
    logic          err_q, err_d;
    logic          fill_q, fill_d;
    logic [1:0]    pending_q, pending_d;

    logic           w_in_ready;
    logic           w_accept;
    logic           w_ram_re;
    logic [RAW-1:0] w_waddr;
    logic [RAW-1:0] w_raddr;
    logic [DW-1:0]  w_ram_rdata;

    assign w_in_ready = !is_held(bank_q[wr_bank_q]);
    assign w_accept   = bus.in_valid && w_in_ready;

    // Banks are laid out back to back so non-power-of-two frames stay dense.
    assign w_waddr = wr_bank_q ? (c_bank1_base + RAW'(wr_cnt_q)) : RAW'(wr_cnt_q);
    assign w_raddr = rd_bank_q ? (c_bank1_base + RAW'(bus.addr[IW-1:0]))
                               : RAW'(bus.addr[IW-1:0]);

    always_comb begin
        bank_d    = bank_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        err_d     = err_q;
        fill_d    = fill_q;
        w_ram_re  = 1'b0;

        if (w_accept) begin
            if (bank_q[wr_bank_q] == BANK_EMPTY) begin
                bank_d[wr_bank_q] = BANK_FILLING;
            end
            if (wr_cnt_q == c_last_idx) begin
                bank_d[wr_bank_q] = BANK_FULL;
                wr_cnt_d          = '0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_cnt_d = wr_cnt_q + 1'b1;
            end
        end

        // start_q is high exactly while the read bank is FULL and idle.
        if (start_q) begin
            bank_d[rd_bank_q] = BANK_READING;
        end

        if (bus.frame_done) begin
            if (bank_q[rd_bank_q] == BANK_READING) begin
                bank_d[rd_bank_q] = BANK_EMPTY;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                err_d = 1'b1;
            end
        end

        if (bus.rd) begin
            if (bank_q[rd_bank_q] == BANK_READING) begin
                fill_d   = ({1'b0, bus.addr} >= c_frame_len);
                w_ram_re = !fill_d;
            end else begin
                fill_d = 1'b1;
                err_d  = 1'b1;
            end
        end
    end

    // Registered start mirrors the next-state handoff condition, giving a
    // pulse in the cycle a frame first sits FULL with no reader active.
    always_comb begin
        start_d   = (bank_d[rd_bank_d] == BANK_FULL)
                 && (bank_d[0] != BANK_READING)
                 && (bank_d[1] != BANK_READING);
        pending_d = 2'(is_held(bank_d[0])) + 2'(is_held(bank_d[1]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0] <= BANK_EMPTY;
            bank_q[1] <= BANK_EMPTY;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            start_q   <= 1'b0;
            err_q     <= 1'b0;
            fill_q    <= 1'b0;
            pending_q <= 2'd0;
        end else begin
            bank_q    <= bank_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            start_q   <= start_d;
            err_q     <= err_d;
            fill_q    <= fill_d;
            pending_q <= pending_d;
        end
    end

    sample_bank_ram #(
        .DW    (DW),
        .DEPTH (2 * FRAME_LEN),
        .ABITS (RAW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (w_accept),
        .waddr_i (w_waddr),
        .wdata_i (bus.in_data),
        .re_i    (w_ram_re),
        .raddr_i (w_raddr),
        .rdata_o (w_ram_rdata)
    );

    assign bus.in_ready       = w_in_ready;
    assign bus.start          = start_q;
    assign bus.data           = fill_q ? {DW{1'b1}} : w_ram_rdata;
    assign bus.frames_pending = pending_q;
    assign bus.err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_hankel_sample_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_hankel_sample_buf
// Description : Directed bench for the ping-pong Hankel sample buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hankel_sample_buf;
    import hankel_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hankel_sample_buf_if #(.DW(HK_DW), .AW(HK_AW)) bus ();

    hankel_sample_buf #(
        .DW        (HK_DW),
        .AW        (HK_AW),
        .FRAME_LEN (HK_FRAME_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          cyc      = 0;
    int          n_checks = 0;
    int          n_err    = 0;
    logic        rd_pend  = 1'b0;
    logic [15:0] exp_data_q [$];
    int          exp_start_q [$];

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_pend <= bus.rd;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: start pulses and read data are popped as they appear.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.start) begin
                check("start_expected", 32'(exp_start_q.size() > 0), 32'd1);
                if (exp_start_q.size() > 0) begin
                    check("start_cycle", cyc, exp_start_q.pop_front());
                end
            end
            if (rd_pend) begin
                check("rd_expected", 32'(exp_data_q.size() > 0), 32'd1);
                if (exp_data_q.size() > 0) begin
                    check("rd_data", {16'd0, bus.data}, {16'd0, exp_data_q.pop_front()});
                end
            end
        end
    end

    task automatic send(input logic [15:0] v, output int acc, output int stalls);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) begin
            check("send_accept_timeout", {31'd0, bus.in_ready}, 32'd1);
        end
        acc    = cyc;
        stalls = n;
        @(posedge clk);
        #1;
    endtask

    task automatic read(input logic [7:0] a, input logic [15:0] e);
        bus.rd   = 1'b1;
        bus.addr = a;
        exp_data_q.push_back(e);
        @(posedge clk);
        #1;
        bus.rd = 1'b0;
    endtask

    task automatic pulse_done(output int fcyc);
        bus.frame_done = 1'b1;
        fcyc = cyc;
        @(posedge clk);
        #1;
        bus.frame_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, st, tot, f;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.rd         = 1'b0;
        bus.addr       = '0;
        bus.frame_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_start", {31'd0, bus.start}, 32'd0);
        check("rst_data", {16'd0, bus.data}, 32'd0);
        check("rst_pending", {30'd0, bus.frames_pending}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        @(posedge clk);
        #1;

        // Frame 0: samples 0..63, start on the cycle after the last accept.
        tot = 0;
        for (int i = 0; i < 64; i++) begin
            send(16'(i), acc, st);
            tot += st;
        end
        bus.in_valid = 1'b0;
        exp_start_q.push_back(acc + 1);
        check("t1_no_stall", tot, 0);
        @(negedge clk);
        check("t1_pending", {30'd0, bus.frames_pending}, 32'd1);
        @(posedge clk);
        #1;

        read(8'd5, 16'd5);
        read(8'd63, 16'd63);
        read(8'd70, FILL_DATA);

        // Frame 1 fills bank 1; the next sample must then stall.
        tot = 0;
        for (int i = 0; i < 64; i++) begin
            send(16'h0100 + 16'(i), acc, st);
            tot += st;
        end
        check("t3_no_stall", tot, 0);
        bus.in_data = 16'h0140;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t3_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("t3_pending", {30'd0, bus.frames_pending}, 32'd2);
            @(posedge clk);
            #1;
        end

        pulse_done(f);
        exp_start_q.push_back(f + 1);
        @(negedge clk);
        check("t4_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        for (int i = 1; i < 64; i++) begin
            send(16'h0140 + 16'(i), acc, st);
        end
        bus.in_valid = 1'b0;
        read(8'd0, 16'h0100);
        read(8'd63, 16'h013F);
        @(negedge clk);
        check("t4_pending", {30'd0, bus.frames_pending}, 32'd2);
        @(posedge clk);
        #1;

        pulse_done(f);
        exp_start_q.push_back(f + 1);
        @(posedge clk);
        #1;
        read(8'd0, 16'h0140);
        read(8'd20, 16'h0154);
        @(negedge clk);
        check("t4_err_clear", {31'd0, bus.err}, 32'd0);
        check("t4_pending_one", {30'd0, bus.frames_pending}, 32'd1);
        @(posedge clk);
        #1;
        pulse_done(f);

        // No bank is READING now: both operations are protocol errors.
        pulse_done(f);
        read(8'd3, FILL_DATA);
        @(negedge clk);
        check("t5_err", {31'd0, bus.err}, 32'd1);
        check("t5_pending", {30'd0, bus.frames_pending}, 32'd0);
        check("t5_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 30; i++) begin
            send(16'h0200 + 16'(i), acc, st);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("t6_start", {31'd0, bus.start}, 32'd0);
        check("t6_data", {16'd0, bus.data}, 32'd0);
        check("t6_pending", {30'd0, bus.frames_pending}, 32'd0);
        check("t6_err", {31'd0, bus.err}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 64; i++) begin
            send(16'h0300 + 16'(i), acc, st);
        end
        bus.in_valid = 1'b0;
        exp_start_q.push_back(acc + 1);
        @(posedge clk);
        #1;
        read(8'd10, 16'h030A);
        read(8'd63, 16'h033F);

        repeat (4) @(posedge clk);
        #1;
        check("start_queue_drained", exp_start_q.size(), 0);
        check("data_queue_drained", exp_data_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
